// File: rtl/sqrt_sched_pkg.sv
// Shared types for the round-robin square-root scheduler.
//   state_e : scheduler FSM states (idle / waiting for the core result)
//   ch_w()  : channel-index width for a given channel count
package sqrt_sched_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  // Index width for n_ch channels; never narrower than one bit.
  function automatic int unsigned ch_w(input int unsigned n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/iterative_sqrt.sv
// Digit-by-digit square root of din * 2^DIN_POINT, one result bit per clock.
// No reset: an operation in flight simply runs to completion.
//   clk        : clock
//   din_valid  : start strobe, honoured only while idle
//   din        : radicand, Q(DIN_WIDTH-DIN_POINT).DIN_POINT
//   dout       : floor(sqrt(din * 2^DIN_POINT)), same Q format as din
//   reminder   : final partial remainder
//   dout_valid : one-cycle strobe with the result
//   busy       : an operation is in flight
module iterative_sqrt #(
  parameter  int unsigned DIN_WIDTH = 16,
  parameter  int unsigned DIN_POINT = 14,
  localparam int unsigned ITERS     = (DIN_WIDTH + DIN_POINT) / 2,
  localparam int unsigned REM_W     = ITERS + 2
) (
  input  logic                 clk,
  input  logic                 din_valid,
  input  logic [DIN_WIDTH-1:0] din,
  output logic [DIN_WIDTH-1:0] dout,
  output logic [REM_W-1:0]     reminder,
  output logic                 dout_valid,
  output logic                 busy
);

  localparam int unsigned RAD_W = 2 * ITERS;
  localparam int unsigned CNT_W = $clog2(ITERS + 1);

  logic [RAD_W-1:0] rad_q, rad_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [ITERS-1:0] root_q, root_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dv_q, dv_d;

  logic [REM_W-1:0] rem_trial;
  logic [REM_W-1:0] sub_val;
  logic [REM_W-1:0] rem_sub;
  logic             take;

  // One restoring step: bring down two radicand bits, try subtracting 4*root+1.
  always_comb begin
    rem_trial = {rem_q[REM_W-3:0], rad_q[RAD_W-1 -: 2]};
    sub_val   = {root_q, 2'b01};
    rem_sub   = rem_trial - sub_val;
    take      = (rem_trial >= sub_val);
  end

  // Next-state: load on start, iterate while the counter runs.
  always_comb begin
    rad_d  = rad_q;
    rem_d  = rem_q;
    root_d = root_q;
    cnt_d  = cnt_q;
    dv_d   = 1'b0;
    if (cnt_q != '0) begin
      rad_d  = rad_q << 2;
      rem_d  = take ? rem_sub : rem_trial;
      root_d = {root_q[ITERS-2:0], take};
      cnt_d  = cnt_q - CNT_W'(1);
      dv_d   = (cnt_q == CNT_W'(1));
    end else if (din_valid) begin
      rad_d  = RAD_W'(din) << DIN_POINT;
      rem_d  = '0;
      root_d = '0;
      cnt_d  = CNT_W'(ITERS);
    end
  end

  always_ff @(posedge clk) begin
    rad_q  <= rad_d;
    rem_q  <= rem_d;
    root_q <= root_d;
    cnt_q  <= cnt_d;
    dv_q   <= dv_d;
  end

  assign dout       = DIN_WIDTH'(root_q);
  assign reminder   = rem_q;
  assign dout_valid = dv_q;
  assign busy       = (cnt_q != '0);

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set bit of pending_i searching
// upward from last_i+1, wrapping modulo N_CH.
//   pending_i : request vector
//   last_i    : index of the previous grant
//   grant_o   : one-hot grant
//   idx_o     : grant index
//   any_o     : some request is pending
module rr_pick
  import sqrt_sched_pkg::*;
#(
  parameter  int unsigned N_CH = 4,
  localparam int unsigned CH_W = ch_w(N_CH)
) (
  input  logic [N_CH-1:0] pending_i,
  input  logic [CH_W-1:0] last_i,
  output logic [N_CH-1:0] grant_o,
  output logic [CH_W-1:0] idx_o,
  output logic            any_o
);

  logic [CH_W-1:0] cand;

  // k runs 1..N_CH so last_i itself is considered last.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      cand = CH_W'((32'(last_i) + k) % N_CH);
      if (!any_o && pending_i[cand]) begin
        any_o         = 1'b1;
        idx_o         = cand;
        grant_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sqrt_rr_scheduler.sv
// Shares one iterative_sqrt core between N_CH channels, each with a one-entry
// holding slot, served in round-robin order; results are tagged by channel.
//   clk, rst    : clock, synchronous active-high reset
//   ch_valid    : per-channel sample strobe
//   ch_din      : channel i at [i*DIN_WIDTH +: DIN_WIDTH]
//   ch_ready    : slot can accept this cycle (combinational)
//   dout        : square root, same Q format as input
//   dout_ch     : channel of dout
//   dout_valid  : one-cycle result strobe
//   ch_overflow : sticky per-channel dropped-sample flag
//   busy        : a slot is pending or a computation is in flight
module sqrt_rr_scheduler
  import sqrt_sched_pkg::*;
#(
  parameter  int unsigned N_CH      = 4,
  parameter  int unsigned DIN_WIDTH = 16,
  parameter  int unsigned DIN_POINT = 14,
  localparam int unsigned CH_W      = ch_w(N_CH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH-1:0]           ch_valid,
  input  logic [N_CH*DIN_WIDTH-1:0] ch_din,
  output logic [N_CH-1:0]           ch_ready,
  output logic [DIN_WIDTH-1:0]      dout,
  output logic [CH_W-1:0]           dout_ch,
  output logic                      dout_valid,
  output logic [N_CH-1:0]           ch_overflow,
  output logic                      busy
);

  localparam int unsigned REM_W = (DIN_WIDTH + DIN_POINT) / 2 + 2;

  state_e               state_q, state_d;
  logic [N_CH-1:0]      pending_q, pending_d;
  logic [N_CH-1:0]      overflow_q, overflow_d;
  logic [DIN_WIDTH-1:0] slot_q [N_CH];
  logic [DIN_WIDTH-1:0] slot_d [N_CH];
  logic [CH_W-1:0]      last_q, last_d;
  logic [CH_W-1:0]      tag_q, tag_d;
  logic [DIN_WIDTH-1:0] dout_q, dout_d;
  logic [CH_W-1:0]      dout_ch_q, dout_ch_d;
  logic                 dout_valid_q, dout_valid_d;

  logic [N_CH-1:0]      issue;
  logic [N_CH-1:0]      load;
  logic [N_CH-1:0]      gnt_oh;
  logic [CH_W-1:0]      gnt_idx;
  logic                 gnt_any;

  logic                 sq_din_valid;
  logic [DIN_WIDTH-1:0] sq_din;
  logic [DIN_WIDTH-1:0] sq_dout;
  logic [REM_W-1:0]     sq_rem_unused;
  logic                 sq_dout_valid;
  logic                 sq_busy;

  rr_pick #(
    .N_CH (N_CH)
  ) u_pick (
    .pending_i (pending_q),
    .last_i    (last_q),
    .grant_o   (gnt_oh),
    .idx_o     (gnt_idx),
    .any_o     (gnt_any)
  );

  iterative_sqrt #(
    .DIN_WIDTH (DIN_WIDTH),
    .DIN_POINT (DIN_POINT)
  ) u_sqrt (
    .clk        (clk),
    .din_valid  (sq_din_valid),
    .din        (sq_din),
    .dout       (sq_dout),
    .reminder   (sq_rem_unused),
    .dout_valid (sq_dout_valid),
    .busy       (sq_busy)
  );

  // FSM next-state and core handshake. Waiting on sq_busy in IDLE covers a
  // core still running from before a reset; its late result lands in IDLE
  // and is ignored.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    tag_d        = tag_q;
    issue        = '0;
    sq_din_valid = 1'b0;
    sq_din       = slot_q[gnt_idx];
    dout_d       = dout_q;
    dout_ch_d    = dout_ch_q;
    dout_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gnt_any && !sq_busy) begin
          issue        = gnt_oh;
          sq_din_valid = 1'b1;
          last_d       = gnt_idx;
          tag_d        = gnt_idx;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (sq_dout_valid) begin
          dout_d       = sq_dout;
          dout_ch_d    = tag_q;
          dout_valid_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A slot being issued this cycle may take a new sample at the same edge.
  assign ch_ready = ~pending_q | issue;
  assign load     = ch_valid & ch_ready;

  always_comb begin
    pending_d  = (pending_q & ~issue) | load;
    overflow_d = overflow_q | (ch_valid & ~ch_ready);
    for (int unsigned i = 0; i < N_CH; i++) begin
      slot_d[i] = load[i] ? ch_din[i*DIN_WIDTH +: DIN_WIDTH] : slot_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pending_q    <= '0;
      overflow_q   <= '0;
      last_q       <= CH_W'(N_CH - 1);
      tag_q        <= '0;
      dout_q       <= '0;
      dout_ch_q    <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      overflow_q   <= overflow_d;
      last_q       <= last_d;
      tag_q        <= tag_d;
      dout_q       <= dout_d;
      dout_ch_q    <= dout_ch_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // Slot data is qualified by pending, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      slot_q[i] <= slot_d[i];
    end
  end

  assign dout        = dout_q;
  assign dout_ch     = dout_ch_q;
  assign dout_valid  = dout_valid_q;
  assign ch_overflow = overflow_q;
  assign busy        = (|pending_q) | (state_q == S_WAIT);

endmodule

// File: tb/tb_sqrt_rr_scheduler.sv
// Directed bench for sqrt_rr_scheduler with N_CH=4, DIN_WIDTH=16, DIN_POINT=14.
module tb_sqrt_rr_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  ch_valid;
  logic [63:0] ch_din;
  logic [3:0]  ch_ready;
  logic [15:0] dout;
  logic [1:0]  dout_ch;
  logic        dout_valid;
  logic [3:0]  ch_overflow;
  logic        busy;

  int checks;
  int errors;

  sqrt_rr_scheduler #(
    .N_CH      (4),
    .DIN_WIDTH (16),
    .DIN_POINT (14)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ch_valid    (ch_valid),
    .ch_din      (ch_din),
    .ch_ready    (ch_ready),
    .dout        (dout),
    .dout_ch     (dout_ch),
    .dout_valid  (dout_valid),
    .ch_overflow (ch_overflow),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    ch_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input int ch, input logic [15:0] val);
    ch_valid             = '0;
    ch_valid[ch]         = 1'b1;
    ch_din[ch*16 +: 16]  = val;
    tick();
    ch_valid = '0;
  endtask

  // Cycles until the next dout_valid (at least one clock), -1 on timeout.
  task automatic wait_valid(input int max_cyc, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!dout_valid && n < max_cyc);
    if (!dout_valid) n = -1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ch_ready !== 4'hF) begin errors++; $display("FAIL reset_ch_ready: got %h expected %h", ch_ready, 4'hF); end
    checks++; if (dout !== 16'h0) begin errors++; $display("FAIL reset_dout: got %h expected %h", dout, 16'h0); end
    checks++; if (dout_ch !== 2'd0) begin errors++; $display("FAIL reset_dout_ch: got %0d expected 0", dout_ch); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid: got %b expected 0", dout_valid); end
    checks++; if (ch_overflow !== 4'h0) begin errors++; $display("FAIL reset_overflow: got %h expected 0", ch_overflow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    repeat (20) tick();
  endtask

  task automatic test_single();
    int n;
    do_reset();
    send(2, 16'h1000);
    wait_valid(40, n);
    checks++; if (n != 17) begin errors++; $display("FAIL single_latency: got %0d expected 17", n); end
    checks++; if (dout !== 16'h2000) begin errors++; $display("FAIL single_dout: got %h expected %h", dout, 16'h2000); end
    checks++; if (dout_ch !== 2'd2) begin errors++; $display("FAIL single_ch: got %0d expected 2", dout_ch); end
    tick();
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL single_pulse: got %b expected 0", dout_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b expected 0", busy); end
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_v [4];
    int n;
    exp_v = '{16'h4000, 16'h2000, 16'h0000, 16'h1000};
    do_reset();
    ch_din   = {16'h0400, 16'h0000, 16'h1000, 16'h4000};
    ch_valid = 4'hF;
    tick();
    ch_valid = '0;
    for (int i = 0; i < 4; i++) begin
      wait_valid(40, n);
      checks++; if (n != 17) begin errors++; $display("FAIL rr_spacing%0d: got %0d expected 17", i, n); end
      checks++; if (dout_ch !== 2'(i)) begin errors++; $display("FAIL rr_ch%0d: got %0d expected %0d", i, dout_ch, i); end
      checks++; if (dout !== exp_v[i]) begin errors++; $display("FAIL rr_dout%0d: got %h expected %h", i, dout, exp_v[i]); end
    end
  endtask

  task automatic test_fairness();
    logic [1:0]  exp_c [6];
    logic [15:0] exp_v [6];
    int n;
    exp_c = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd3, 2'd0};
    exp_v = '{16'h2000, 16'h4000, 16'h1000, 16'h0800, 16'h1800, 16'h0200};
    do_reset();
    // ch1 granted first; then ch0 and ch1 both pending while the core runs.
    send(1, 16'h1000);
    repeat (3) tick();
    ch_din[15:0]  = 16'h4000;
    ch_din[31:16] = 16'h0400;
    ch_valid      = 4'b0011;
    tick();
    ch_valid = '0;
    for (int i = 0; i < 3; i++) begin
      wait_valid(60, n);
      checks++; if (dout_ch !== exp_c[i] || dout !== exp_v[i]) begin errors++; $display("FAIL fair_a%0d: got ch%0d %h expected ch%0d %h", i, dout_ch, dout, exp_c[i], exp_v[i]); end
    end
    // ch0 granted, then reloaded alongside ch3: ch3 must go next.
    repeat (2) tick();
    send(0, 16'h0100);
    repeat (2) tick();
    ch_din[15:0]  = 16'h0010;
    ch_din[63:48] = 16'h0900;
    ch_valid      = 4'b1001;
    tick();
    ch_valid = '0;
    for (int i = 3; i < 6; i++) begin
      wait_valid(60, n);
      checks++; if (dout_ch !== exp_c[i] || dout !== exp_v[i]) begin errors++; $display("FAIL fair_b%0d: got ch%0d %h expected ch%0d %h", i, dout_ch, dout, exp_c[i], exp_v[i]); end
    end
  endtask

  task automatic test_overflow();
    int n;
    do_reset();
    send(0, 16'h1000);
    send(3, 16'h0400);
    checks++; if (ch_ready !== 4'b0111) begin errors++; $display("FAIL ovf_ready: got %b expected 0111", ch_ready); end
    send(3, 16'h4000);
    checks++; if (ch_overflow !== 4'b1000) begin errors++; $display("FAIL ovf_flag: got %b expected 1000", ch_overflow); end
    wait_valid(40, n);
    checks++; if (dout_ch !== 2'd0 || dout !== 16'h2000) begin errors++; $display("FAIL ovf_first: got ch%0d %h expected ch0 2000", dout_ch, dout); end
    wait_valid(40, n);
    checks++; if (dout_ch !== 2'd3 || dout !== 16'h1000) begin errors++; $display("FAIL ovf_kept: got ch%0d %h expected ch3 1000", dout_ch, dout); end
    wait_valid(30, n);
    checks++; if (n != -1) begin errors++; $display("FAIL ovf_extra: got result after %0d cycles expected none", n); end
    checks++; if (ch_overflow !== 4'b1000) begin errors++; $display("FAIL ovf_sticky: got %b expected 1000", ch_overflow); end
    do_reset();
    checks++; if (ch_overflow !== 4'b0000) begin errors++; $display("FAIL ovf_clear: got %b expected 0000", ch_overflow); end
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    send(1, 16'h4000);
    checks++; if (ch_ready[1] !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", ch_ready[1]); end
    send(1, 16'h1000);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", busy); end
    wait_valid(40, n);
    checks++; if (n != 16 || dout_ch !== 2'd1 || dout !== 16'h4000) begin errors++; $display("FAIL b2b_first: got n=%0d ch%0d %h expected n=16 ch1 4000", n, dout_ch, dout); end
    wait_valid(40, n);
    checks++; if (n != 17 || dout_ch !== 2'd1 || dout !== 16'h2000) begin errors++; $display("FAIL b2b_second: got n=%0d ch%0d %h expected n=17 ch1 2000", n, dout_ch, dout); end
    checks++; if (ch_overflow !== 4'b0000) begin errors++; $display("FAIL b2b_overflow: got %b expected 0000", ch_overflow); end
  endtask

  task automatic test_mid_reset();
    int n;
    do_reset();
    send(2, 16'h0400);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || dout_valid !== 1'b0) begin errors++; $display("FAIL midrst_state: got busy=%b dv=%b expected 0 0", busy, dout_valid); end
    send(0, 16'h0100);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy: got %b expected 1", busy); end
    // Core frees after its stale run; ch0 issues then and returns 26 cycles on.
    wait_valid(60, n);
    checks++; if (n != 26) begin errors++; $display("FAIL midrst_latency: got %0d expected 26", n); end
    checks++; if (dout_ch !== 2'd0 || dout !== 16'h0800) begin errors++; $display("FAIL midrst_result: got ch%0d %h expected ch0 0800", dout_ch, dout); end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    ch_valid = '0;
    ch_din   = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
